// File: rtl/countone_arb_pkg.sv
// Shared types and defaults for the countone stream arbiter.
package countone_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned WDOG_LIMIT_DEFAULT = 1024;
  localparam int unsigned ID_DEPTH_DEFAULT   = 4;

  // Requester ID width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/countone_id_fifo.sv
// Synchronous FIFO holding the source IDs of packets whose result is still outstanding.
// Head reads as zero while empty so the tagged output never shows stale IDs.
module countone_id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/countone_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one countone kernel; results tagged with source ID.
// Optional stall watchdog built when COUNTONE_ARB_WATCHDOG_EN is defined.
//   state    | meaning
//   ST_IDLE  | no packet owns the kernel; arbitrate when the ID FIFO has room
//   ST_GRANT | gnt_id streams its packet to the kernel until the TLAST beat
module countone_stream_arbiter
  import countone_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ID_DEPTH   = ID_DEPTH_DEFAULT,
  parameter int unsigned WDOG_LIMIT = WDOG_LIMIT_DEFAULT,
  localparam int unsigned ID_W      = id_width(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        s_tvalid,
  output logic [N_REQ-1:0]        s_tready,
  input  logic [N_REQ*DATA_W-1:0] s_tdata,
  input  logic [N_REQ-1:0]        s_tlast,
  output logic                    k_tvalid,
  input  logic                    k_tready,
  output logic [DATA_W-1:0]       k_tdata,
  output logic                    k_tlast,
  input  logic                    r_tvalid,
  output logic                    r_tready,
  input  logic [DATA_W-1:0]       r_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic [ID_W-1:0]         m_tid,
  output logic                    busy,
  output logic                    err_orphan,
  output logic                    wdog_block,
  output logic [ID_W-1:0]         wdog_src
);

  arb_state_e      state;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick_id;
  logic            pick_vld;
  logic            grant_fire;
  logic            pkt_done;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ID_W-1:0] fifo_head;
  logic            fifo_pop;
  int              off;
  int              best_off;

  // Smallest cyclic distance from rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    best_off = int'(N_REQ);
    off      = 0;
    for (int j = 0; j < int'(N_REQ); j++) begin
      off = (j + int'(N_REQ) - int'(rr_ptr)) % int'(N_REQ);
      if (s_tvalid[j] && (off < best_off)) begin
        best_off = off;
        pick_id  = ID_W'(j);
        pick_vld = 1'b1;
      end
    end
  end

  assign grant_fire = (state == ST_IDLE) & pick_vld & ~fifo_full;
  assign pkt_done   = (state == ST_GRANT) & k_tvalid & k_tready & k_tlast;

  always_comb begin
    k_tvalid = 1'b0;
    k_tdata  = '0;
    k_tlast  = 1'b0;
    s_tready = '0;
    if (state == ST_GRANT) begin
      for (int j = 0; j < int'(N_REQ); j++) begin
        if (gnt_id == ID_W'(j)) begin
          k_tvalid    = s_tvalid[j];
          k_tdata     = s_tdata[j*DATA_W +: DATA_W];
          k_tlast     = s_tlast[j];
          s_tready[j] = k_tready;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      gnt_id <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            gnt_id <= pick_id;
            state  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (pkt_done) begin
            state  <= ST_IDLE;
            rr_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  countone_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (ID_DEPTH)
  ) u_id_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (grant_fire),
    .push_data (pick_id),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // A result with no outstanding ID is never accepted, so it cannot pop anything.
  assign m_tvalid = r_tvalid & ~fifo_empty;
  assign r_tready = m_tready & ~fifo_empty;
  assign m_tdata  = fifo_empty ? '0 : r_tdata;
  assign m_tid    = fifo_head;
  assign fifo_pop = m_tvalid & m_tready;
  assign busy     = (state == ST_GRANT) | ~fifo_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     err_orphan <= 1'b0;
    else if (r_tvalid && fifo_empty)  err_orphan <= 1'b1;
  end

`ifdef COUNTONE_ARB_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);

  logic [WD_W-1:0] wdog_cnt;
  logic            stall;

  assign stall = ((state == ST_GRANT) & k_tvalid & ~k_tready) | (r_tvalid & ~r_tready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt   <= '0;
      wdog_block <= 1'b0;
      wdog_src   <= '0;
    end else begin
      if (!stall)                              wdog_cnt <= '0;
      else if (wdog_cnt != WD_W'(WDOG_LIMIT))  wdog_cnt <= wdog_cnt + WD_W'(1);
      if (stall && (wdog_cnt == WD_W'(WDOG_LIMIT - 1)) && !wdog_block) begin
        wdog_block <= 1'b1;
        wdog_src   <= gnt_id;
      end
    end
  end
`else
  assign wdog_block = 1'b0;
  assign wdog_src   = '0;
`endif

endmodule

// File: tb/tb_countone_stream_arbiter.sv
// Bench for countone_stream_arbiter: directed scenarios plus randomized packets against a round-robin model.
module tb_countone_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int WL = 16;

`ifdef COUNTONE_ARB_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic [N-1:0]  s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic          k_tvalid, k_tready, k_tlast;
  logic [DW-1:0] k_tdata;
  logic          r_tvalid, r_tready;
  logic [DW-1:0] r_tdata;
  logic          m_tvalid, m_tready;
  logic [DW-1:0] m_tdata;
  logic [1:0]    m_tid;
  logic          busy, err_orphan, wdog_block;
  logic [1:0]    wdog_src;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  countone_stream_arbiter #(
    .N_REQ(N), .DATA_W(DW), .ID_DEPTH(DEPTH), .WDOG_LIMIT(WL)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .k_tvalid(k_tvalid), .k_tready(k_tready), .k_tdata(k_tdata), .k_tlast(k_tlast),
    .r_tvalid(r_tvalid), .r_tready(r_tready), .r_tdata(r_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tid(m_tid),
    .busy(busy), .err_orphan(err_orphan), .wdog_block(wdog_block), .wdog_src(wdog_src)
  );

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0;
    k_tready = 1'b0; r_tvalid = 1'b0; r_tdata = '0; m_tready = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s_tvalid = '1; s_tlast = '1; s_tdata = '1;
    k_tready = 1'b1; m_tready = 1'b1; r_tvalid = 1'b0; r_tdata = '0;
    @(negedge clock); #1;
    tests++;
    if ({s_tready, k_tvalid, k_tlast, r_tready, m_tvalid, busy, err_orphan, wdog_block} !== 11'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0", {s_tready, k_tvalid, k_tlast, r_tready, m_tvalid, busy, err_orphan, wdog_block});
    end
    tests++;
    if ({k_tdata, m_tdata, m_tid, wdog_src} !== 68'b0) begin
      fails++;
      $display("FAIL reset_data: got k=%h m=%h tid=%0d src=%0d want 0", k_tdata, m_tdata, m_tid, wdog_src);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] d [3];
    do_reset();
    for (int b = 0; b < 3; b++) d[b] = $urandom;
    k_tready = 1'b1;
    s_tvalid = 4'b0100; s_tdata[2*DW +: DW] = d[0]; s_tlast = '0;
    step();
    for (int b = 0; b < 3; b++) begin
      s_tdata[2*DW +: DW] = d[b];
      s_tlast[2] = (b == 2);
      #1;
      tests++;
      if (k_tvalid !== 1'b1 || k_tdata !== d[b] || k_tlast !== (b == 2) || s_tready !== 4'b0100 || busy !== 1'b1) begin
        fails++;
        $display("FAIL single_beat%0d: got v=%b d=%h l=%b rdy=%b busy=%b want v=1 d=%h l=%0d rdy=0100 busy=1",
                 b, k_tvalid, k_tdata, k_tlast, s_tready, busy, d[b], (b == 2));
      end
      step();
    end
    s_tvalid = '0; s_tlast = '0;
    #1;
    tests++;
    if (k_tvalid !== 1'b0 || s_tready !== 4'b0000) begin
      fails++;
      $display("FAIL single_after_last: got v=%b rdy=%b want 0 0000", k_tvalid, s_tready);
    end
    r_tvalid = 1'b1; r_tdata = 32'h5; m_tready = 1'b1;
    #1;
    tests++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h5 || m_tid !== 2'd2 || r_tready !== 1'b1) begin
      fails++;
      $display("FAIL single_result: got v=%b d=%h id=%0d rr=%b want 1 5 2 1", m_tvalid, m_tdata, m_tid, r_tready);
    end
    step();
    r_tvalid = 1'b0; m_tready = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL single_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_contend();
    int pending;
    int exp_id;
    int idq[$];
    do_reset();
    k_tready = 1'b1; m_tready = 1'b1; s_tvalid = '1; s_tlast = '1;
    for (int j = 0; j < N; j++) s_tdata[j*DW +: DW] = 32'(100 + j);
    pending = 0;
    for (int n = 0; n < 10; n++) begin
      r_tvalid = (pending > 0);
      r_tdata = 32'(n);
      #1;
      tests++;
      if (n % 2 == 0) begin
        if (k_tvalid !== 1'b0 || s_tready !== 4'b0000) begin
          fails++;
          $display("FAIL contend_idle%0d: got v=%b rdy=%b want 0 0000", n, k_tvalid, s_tready);
        end
      end else begin
        exp_id = ((n - 1) / 2) % N;
        if (k_tvalid !== 1'b1 || s_tready !== (4'b0001 << exp_id) || k_tdata !== 32'(100 + exp_id)) begin
          fails++;
          $display("FAIL contend_grant%0d: got rdy=%b d=%0d want req %0d", n, s_tready, k_tdata, exp_id);
        end
        if (k_tvalid && k_tready && k_tlast) begin
          pending++;
          idq.push_back(exp_id);
        end
      end
      if (m_tvalid && m_tready) begin
        tests++;
        if (idq.size() == 0 || m_tid !== 2'(idq[0])) begin
          fails++;
          $display("FAIL contend_tid: got %0d want %0d", m_tid, (idq.size() > 0) ? idq[0] : -1);
        end
        if (idq.size() > 0) void'(idq.pop_front());
        pending--;
      end
      step();
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    k_tready = 1'b1; s_tvalid = '1; s_tlast = '1;
    for (int j = 0; j < N; j++) s_tdata[j*DW +: DW] = 32'(j);
    repeat (8) step();
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (s_tready !== 4'b0000 || k_tvalid !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL full_hold%0d: got rdy=%b v=%b busy=%b want 0000 0 1", c, s_tready, k_tvalid, busy);
      end
      step();
    end
    r_tvalid = 1'b1; m_tready = 1'b1; r_tdata = 32'h33;
    #1;
    tests++;
    if (m_tvalid !== 1'b1 || m_tid !== 2'd0 || s_tready !== 4'b0000) begin
      fails++;
      $display("FAIL full_pop: got v=%b id=%0d rdy=%b want 1 0 0000", m_tvalid, m_tid, s_tready);
    end
    step();
    r_tvalid = 1'b0; m_tready = 1'b0;
    #1;
    tests++;
    if (s_tready !== 4'b0000) begin
      fails++;
      $display("FAIL full_arb_cycle: got rdy=%b want 0000", s_tready);
    end
    step();
    #1;
    tests++;
    if (s_tready !== 4'b0001 || k_tvalid !== 1'b1) begin
      fails++;
      $display("FAIL full_fifth_grant: got rdy=%b v=%b want 0001 1", s_tready, k_tvalid);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    r_tvalid = 1'b1; m_tready = 1'b1; r_tdata = 32'h7;
    #1;
    tests++;
    if (r_tready !== 1'b0 || m_tvalid !== 1'b0 || err_orphan !== 1'b0) begin
      fails++;
      $display("FAIL orphan_comb: got rr=%b mv=%b err=%b want 0 0 0", r_tready, m_tvalid, err_orphan);
    end
    step();
    r_tvalid = 1'b0;
    #1;
    tests++;
    if (err_orphan !== 1'b1) begin
      fails++;
      $display("FAIL orphan_set: got %b want 1", err_orphan);
    end
    step();
    #1;
    tests++;
    if (err_orphan !== 1'b1) begin
      fails++;
      $display("FAIL orphan_sticky: got %b want 1", err_orphan);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    s_tvalid = 4'b0010; s_tlast = '0; s_tdata[DW +: DW] = 32'hABCD; k_tready = 1'b0;
    step();
    repeat (15) step();
    #1;
    tests++;
    if (wdog_block !== 1'b0) begin
      fails++;
      $display("FAIL wdog_early: got %b want 0", wdog_block);
    end
    step();
    #1;
    tests++;
    if (wdog_block !== WD_ON || wdog_src !== (WD_ON ? 2'd1 : 2'd0)) begin
      fails++;
      $display("FAIL wdog_trip: got blk=%b src=%0d want %b %0d", wdog_block, wdog_src, WD_ON, WD_ON ? 1 : 0);
    end
    repeat (5) step();
    #1;
    tests++;
    if (wdog_block !== WD_ON) begin
      fails++;
      $display("FAIL wdog_sticky: got %b want %b", wdog_block, WD_ON);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    k_tready = 1'b1;
    s_tvalid = 4'b0010; s_tlast = 4'b0010;
    step();
    step();
    s_tvalid = 4'b0100; s_tlast = '0;
    step();
    step();
    #1;
    tests++;
    if (s_tready !== 4'b0100 || k_tvalid !== 1'b1) begin
      fails++;
      $display("FAIL midrst_beat2: got rdy=%b v=%b want 0100 1", s_tready, k_tvalid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (s_tready !== 4'b0000 || k_tvalid !== 1'b0 || busy !== 1'b0 || m_tid !== 2'd0) begin
      fails++;
      $display("FAIL midrst_async: got rdy=%b v=%b busy=%b tid=%0d want all 0", s_tready, k_tvalid, busy, m_tid);
    end
    @(negedge clock);
    reset_n = 1'b1;
    s_tvalid = '1; s_tlast = '1;
    step();
    #1;
    tests++;
    if (s_tready !== 4'b0001) begin
      fails++;
      $display("FAIL midrst_next_grant: got rdy=%b want 0001", s_tready);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] bd [N][16];
    bit            bl [N][16];
    int            blen[N], bpos[N], mpos[N], rem[N];
    logic [DW-1:0] exp_kd[$];
    bit            exp_kl[$];
    int            exp_kid[$];
    logic [DW-1:0] exp_md[$];
    int            exp_mid[$];
    logic [DW-1:0] kres[$];
    logic [DW-1:0] acc, kacc;
    int            len, ptr, pick, total, cyc;
    bit            last;

    do_reset();
    total = 0;
    for (int r = 0; r < N; r++) begin
      blen[r] = 0; bpos[r] = 0; mpos[r] = 0;
      rem[r] = $urandom_range(1, 3);
      total += rem[r];
      for (int p = 0; p < rem[r]; p++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          bd[r][blen[r]] = $urandom;
          bl[r][blen[r]] = (b == len - 1);
          blen[r]++;
        end
      end
    end
    // Model: continuously-valid requesters served whole-packet in cyclic order.
    ptr = 0;
    for (int t = 0; t < total; t++) begin
      pick = -1;
      for (int o = N - 1; o >= 0; o--) if (rem[(ptr + o) % N] > 0) pick = (ptr + o) % N;
      acc = '0;
      do begin
        exp_kd.push_back(bd[pick][mpos[pick]]);
        exp_kl.push_back(bl[pick][mpos[pick]]);
        exp_kid.push_back(pick);
        acc += DW'($countones(bd[pick][mpos[pick]]));
        last = bl[pick][mpos[pick]];
        mpos[pick]++;
      end while (!last);
      exp_md.push_back(acc);
      exp_mid.push_back(pick);
      rem[pick]--;
      ptr = (pick + 1) % N;
    end

    kacc = '0;
    cyc = 0;
    while ((exp_kd.size() > 0 || exp_md.size() > 0) && cyc < 4000) begin
      for (int r = 0; r < N; r++) begin
        s_tvalid[r] = (bpos[r] < blen[r]);
        s_tdata[r*DW +: DW] = s_tvalid[r] ? bd[r][bpos[r]] : '0;
        s_tlast[r] = s_tvalid[r] ? bl[r][bpos[r]] : 1'b0;
      end
      k_tready = ($urandom_range(0, 3) != 0);
      r_tvalid = (kres.size() > 0) && ($urandom_range(0, 3) != 0);
      r_tdata  = (kres.size() > 0) ? kres[0] : '0;
      m_tready = ($urandom_range(0, 3) != 0);
      #1;
      if (k_tvalid && k_tready) begin
        tests++;
        if (exp_kd.size() == 0) begin
          fails++;
          $display("FAIL rand_k_extra: got beat %h want none", k_tdata);
        end else begin
          if (k_tdata !== exp_kd[0] || k_tlast !== exp_kl[0] || s_tready !== (4'b0001 << exp_kid[0])) begin
            fails++;
            $display("FAIL rand_k_beat: got d=%h l=%b rdy=%b want d=%h l=%b req=%0d",
                     k_tdata, k_tlast, s_tready, exp_kd[0], exp_kl[0], exp_kid[0]);
          end
          void'(exp_kd.pop_front()); void'(exp_kl.pop_front()); void'(exp_kid.pop_front());
        end
        for (int r = 0; r < N; r++) if (s_tready[r] && s_tvalid[r]) bpos[r]++;
        kacc += DW'($countones(k_tdata));
        if (k_tlast) begin
          kres.push_back(kacc);
          kacc = '0;
        end
      end
      if (m_tvalid && m_tready) begin
        tests++;
        if (exp_md.size() == 0) begin
          fails++;
          $display("FAIL rand_m_extra: got d=%h id=%0d want none", m_tdata, m_tid);
        end else begin
          if (m_tdata !== exp_md[0] || m_tid !== 2'(exp_mid[0])) begin
            fails++;
            $display("FAIL rand_m: got d=%h id=%0d want d=%h id=%0d", m_tdata, m_tid, exp_md[0], exp_mid[0]);
          end
          void'(exp_md.pop_front()); void'(exp_mid.pop_front());
        end
        if (kres.size() > 0) void'(kres.pop_front());
      end
      step();
      cyc++;
    end
    tests++;
    if (cyc >= 4000) begin
      fails++;
      $display("FAIL rand_timeout: got %0d beats %0d results left want 0", exp_kd.size(), exp_md.size());
    end
    tests++;
    if (err_orphan !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rand_end_state: got err=%b busy=%b want 0 0", err_orphan, busy);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0;
    k_tready = 1'b0; r_tvalid = 1'b0; r_tdata = '0; m_tready = 1'b0;
    test_reset();
    test_single();
    test_contend();
    test_fifo_full();
    test_orphan();
    test_watchdog();
    test_mid_reset();
    for (int i = 0; i < 4; i++) test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/countone_stream_arbiter.md
# countone_stream_arbiter

Packet-level round-robin arbiter that shares the single countone kernel between `N_REQ` AXI-Stream requesters. Whole input packets (delimited by TLAST) are granted atomically onto the kernel input stream. The source ID of each granted packet is queued, and the one-beat result the kernel returns per packet is tagged with that ID. An optional stall watchdog flags a deadlocked kernel handshake and reports which requester was blocked.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 32, input and result data width
- `ID_DEPTH`, 4, outstanding-packet ID FIFO depth (power of two)
- `WDOG_LIMIT`, 1024, stall cycles before the watchdog trips

Ports:
- `clock` in 1, sole clock
- `reset_n` in 1, asynchronous active-low reset
- `s_tvalid` in N_REQ, requester valid
- `s_tready` out N_REQ, requester ready
- `s_tdata` in N_REQ*DATA_W, requester data; requester i occupies bits [i*DATA_W +: DATA_W]
- `s_tlast` in N_REQ, requester end-of-packet
- `k_tvalid` / `k_tready` / `k_tdata` / `k_tlast`, out / in / out DATA_W / out, stream to the kernel input
- `r_tvalid` / `r_tready` / `r_tdata`, in / out / in DATA_W, kernel result stream, one beat per packet
- `m_tvalid` / `m_tready` / `m_tdata` / `m_tid`, out / in / out DATA_W / out clog2(N_REQ), tagged result output
- `busy` out 1, high while in GRANT or while the ID FIFO is non-empty
- `err_orphan` out 1, sticky; a result arrived while the ID FIFO was empty
- `wdog_block` out 1, sticky watchdog trip
- `wdog_src` out clog2(N_REQ), requester granted at the moment of the trip

## Operation
- FSM has two states, IDLE and GRANT.
- **IDLE.** If any `s_tvalid` is high and the ID FIFO is not full, pick the first requester at or after `rr_ptr` (cyclic order).
  - Register `gnt_id`, push `gnt_id` into the ID FIFO, go to GRANT.
- **GRANT.** Connect the granted requester to the kernel:
  - `k_tvalid = s_tvalid[gnt_id]`
  - `s_tready[gnt_id] = k_tready`
  - `k_tdata` and `k_tlast` come from the granted requester.
  - All other `s_tready` are 0.
- **End of packet.** A handshake on the kernel input with `k_tlast` high:
  - returns the FSM to IDLE;
  - sets `rr_ptr = (gnt_id + 1) mod N_REQ`.
- **Result path:**
  - `m_tvalid = r_tvalid & ~fifo_empty`
  - `r_tready = m_tready & ~fifo_empty`
  - `m_tdata = r_tdata`, `m_tid = fifo_head`
  - A handshake on `m_*` pops the FIFO.
- **Orphan result.** If `r_tvalid` is high while the FIFO is empty, set `err_orphan` (sticky) and hold `r_tready` at 0.
- **Simultaneous push and pop.** Both take effect and the count is unchanged. A push is only issued when the FIFO is not full at arbitration time.
- **FIFO full.** IDLE holds and no grant is issued. `s_tready` is all 0.
- **Reset mid-packet.** The packet is abandoned. FIFO, FSM, `rr_ptr` and sticky flags clear immediately, with no drain.
- **Reset values:**
  - `s_tready`, `k_tvalid`, `k_tlast`, `r_tready`, `m_tvalid`, `busy`, `err_orphan`, `wdog_block`: 0
  - `k_tdata`, `m_tdata`, `m_tid`, `wdog_src`: 0
  - `rr_ptr`: 0

## Timing
- Arbitration latency: 1 cycle. A grant decided in IDLE in cycle t makes its first beat eligible in cycle t+1.
- One bubble cycle between back-to-back packets (the IDLE cycle).
- Kernel input path: combinational mux from the `s_*` inputs, no pipeline register.
- Result path: combinational, zero latency.
- ID FIFO count width: clog2(ID_DEPTH+1). Pointers wrap modulo ID_DEPTH.
- Watchdog counter saturates at WDOG_LIMIT.

## Configuration
- Macro: `COUNTONE_ARB_WATCHDOG_EN`.
- **Defined:**
  - A counter increments every cycle in which (GRANT and `k_tvalid` and not `k_tready`) or (`r_tvalid` and not `r_tready`).
  - It resets to 0 on any cycle without such a stall.
  - On reaching WDOG_LIMIT, `wdog_block` is set (sticky until reset) and `wdog_src` latches `gnt_id`.
- **Undefined:** the counter is not built, and `wdog_block` and `wdog_src` are tied to 0. The port list is the same in both builds.

## Structure
- Package `countone_arb_pkg` holds:
  - the FSM state enum (IDLE, GRANT);
  - the `id_t` width function clog2(N_REQ);
  - the default values of `WDOG_LIMIT` and `ID_DEPTH`.
- Sub-module `countone_id_fifo`: synchronous FIFO with `reset_n` and push/pop/full/empty/head. It is instantiated once for the ID queue.

## Test plan
- **Single request.** Requester 2 sends a 3-beat packet and the kernel returns result 0x5 → the kernel sees 3 beats (`k_tlast` on beat 3), and the output shows `m_tdata`=0x5, `m_tid`=2.
- **All contending.** All 4 requesters hold 1-beat packets → grant order 0,1,2,3,0, with one IDLE cycle between grants.
- **FIFO full.** ID_DEPTH=4 and results are withheld → after 4 grants `s_tready` stays 0. Releasing one result (pop) allows a 5th grant 2 cycles later.
- **Orphan result.** `r_tvalid` driven with the FIFO empty → `err_orphan`=1, `r_tready`=0, `m_tvalid`=0.
- **Watchdog** (macro on, WDOG_LIMIT=16). Requester 1 is granted and `k_tready` held at 0 → `wdog_block` rises after 16 stall cycles with `wdog_src`=1. With the macro off, `wdog_block` stays 0.
- **Mid-packet reset.** `reset_n` asserted during beat 2 of a 4-beat packet → all outputs return to 0 asynchronously, and the next grant after release goes to requester 0.
